// File: rtl/mem_sequencer.sv
// Shares one single-ported memory between instruction fetch and load/store
// traffic, pulsing cpu_step once per committed instruction.
module mem_sequencer #(
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_pc,
  input  logic        cpu_load,
  input  logic        cpu_store,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_store_data,
  output logic [31:0] cpu_inst,
  output logic [31:0] cpu_load_data,
  output logic        cpu_step,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DATA,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_busy;
  logic             w_expire;

  assign w_busy   = (r_state == S_FETCH) || (r_state == S_DATA);
  // Expire on the cycle the counter would reach TIMEOUT, so HALT follows
  // exactly TIMEOUT unacknowledged request cycles.
  assign w_expire = (TIMEOUT != 0) && !mem_ack && ((32'(r_cnt) + 32'd1) >= TIMEOUT);
  assign bus_err  = (r_state == S_HALT);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_busy && !mem_ack) begin
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_step  = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = cpu_pc;
        if (mem_ack) begin
          w_next = S_EXEC;
        end else if (w_expire) begin
          w_next = S_HALT;
        end
      end
      S_EXEC: begin
        if (cpu_store || cpu_load) begin
          w_next = S_DATA;
        end else begin
          cpu_step = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_DATA: begin
        mem_req   = 1'b1;
        mem_we    = cpu_store;
        mem_addr  = cpu_address;
        mem_wdata = cpu_store ? cpu_store_data : '0;
        if (mem_ack) begin
          w_next = S_COMMIT;
        end else if (w_expire) begin
          w_next = S_HALT;
        end
      end
      S_COMMIT: begin
        cpu_step = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // Store wins over load, so a simultaneous load never updates load data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_inst      <= NOP_INST;
      cpu_load_data <= '0;
    end else begin
      if (r_state == S_FETCH && mem_ack) begin
        cpu_inst <= mem_rdata;
      end
      if (r_state == S_DATA && mem_ack && cpu_load && !cpu_store) begin
        cpu_load_data <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Multi-cycle sequencer that shares one single-ported memory between instruction fetch and load/store data access for the single-cycle RV32 core.
- Fetches the instruction at the core's pc and presents it, stable, to the core.
- If the decoded instruction is a load or store, runs a second memory transaction.
- Pulses cpu_step to let the core commit exactly one instruction.
- Sits between the core and the memory/bus; the core's pc and register file update only when cpu_step is high.

Parameters:
NOP_INST, 32'h00000013, instruction presented on cpu_inst out of reset (addi x0,x0,0)
TIMEOUT, 255, max cycles mem_req may wait for mem_ack before bus error; 0 disables timeout

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_pc  input  32  core program counter (fetch address)
cpu_load  input  1  core decodes a load
cpu_store  input  1  core decodes a store
cpu_address  input  32  core data address
cpu_store_data  input  32  core store data
cpu_inst  output  32  registered instruction to core
cpu_load_data  output  32  registered load data to core
cpu_step  output  1  one-cycle commit/clock-enable pulse to core
mem_req  output  1  memory request, held until acknowledged
mem_we  output  1  1 = write, 0 = read
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid with mem_ack
mem_ack  input  1  transaction complete, sampled on rising clock edge
bus_err  output  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; ports are named clock and reset.
- Reset values:
  - state = IDLE; mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_step = 0, bus_err = 0, cpu_inst = NOP_INST, cpu_load_data = 0, timeout counter = 0.
- Output timing: mem_* and cpu_step are combinational from state and inputs; cpu_inst and cpu_load_data are registers.
- IDLE: no request. Go to FETCH on the first clock after reset deasserts.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=cpu_pc, mem_wdata=0.
  - On mem_ack: cpu_inst <= mem_rdata; go to EXEC.
- EXEC:
  - mem_req=0. The core now decodes the stable cpu_inst.
  - cpu_store=1: go to DATA (store has priority if cpu_load and cpu_store are both high; no load data is latched).
  - Else cpu_load=1: go to DATA.
  - Else: cpu_step=1 this cycle; go to FETCH.
- DATA:
  - Drives mem_req=1, mem_addr=cpu_address, mem_we=cpu_store, mem_wdata = cpu_store ? cpu_store_data : 0.
  - On mem_ack: if load, cpu_load_data <= mem_rdata; go to COMMIT.
- COMMIT: mem_req=0; cpu_step=1 for exactly one cycle; go to FETCH.
- HALT: entered on timeout. mem_req=0, cpu_step=0, bus_err=1. Left only by reset.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ack=0.
  - A zero-wait ack (same cycle as request) is legal.
  - mem_ack while mem_req=0 is ignored; this includes late acks after reset.
  - mem_req is always low for at least one cycle between transactions.
- Latency with zero-wait memory:
  - Non-memory instruction: 2 cycles per instruction (FETCH, EXEC).
  - Load/store: 4 cycles (FETCH, EXEC, DATA, COMMIT).
  - Each wait state adds 1 cycle.
- Stability guarantees:
  - cpu_inst changes only on a FETCH ack; it is never modified in EXEC, DATA or COMMIT.
  - cpu_load_data changes only on a load ack in DATA.
- Timeout:
  - The counter resets to 0 on entry to FETCH/DATA and on ack, and increments each cycle in FETCH/DATA without ack.
  - When it reaches TIMEOUT with no ack, go to HALT. The counter saturates and never wraps.
  - TIMEOUT=0 disables the timeout.
  - Counter width is clog2(TIMEOUT+1), minimum 1.
- Reset mid-transaction: mem_req drops immediately (asynchronously); no cpu_step is issued for the interrupted instruction.
- cpu_step is never asserted in IDLE, FETCH, DATA or HALT.

Test Plan:
- Reset, zero-wait memory, cpu_pc=0, rdata=32'h00500093, load=store=0 -> first mem_req in cycle after reset release with addr 0; cpu_inst=32'h00500093; cpu_step pulses every 2nd cycle.
- Load, 2 wait states, cpu_address=32'h100, rdata=32'hDEADBEEF -> DATA: mem_req=1, we=0, addr 0x100 held 3 cycles; cpu_load_data=32'hDEADBEEF before cpu_step; single cpu_step.
- Store, cpu_address=32'h104, cpu_store_data=32'h12345678 -> DATA: we=1, wdata=32'h12345678; exactly one ack consumed; cpu_load_data unchanged; one cpu_step.
- TIMEOUT=4, mem_ack never asserted -> bus_err=1 after 4 request cycles; mem_req=0 and no cpu_step thereafter; reset clears bus_err and restarts fetch.
- Reset asserted mid-DATA with ack arriving the cycle after -> mem_req low immediately; cpu_inst=NOP_INST; stray ack ignored; no cpu_step.
- cpu_load and cpu_store both 1 -> we=1, store path taken, cpu_load_data not updated.
